// File: rtl/puf_reader_pkg.sv
// Shared defaults, derived widths and FSM state type for the PUF response reader.
package puf_reader_pkg;

    localparam int unsigned BPC        = 4;
    localparam int unsigned DBW        = 64;
    localparam int unsigned MNC        = 4096;
    localparam int unsigned RD_LAT_DEF = 1;

    localparam int unsigned NCMPS_W = $clog2(MNC) + 1;
    localparam int unsigned ADDR_W  = $clog2(MNC * BPC / DBW - 1);
    localparam int unsigned ADDW_W  = $clog2(MNC * BPC / DBW) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StAddr,
        StHold,
        StCsum,
        StDone
    } puf_state_e;

endpackage

// File: rtl/puf_reader_if.sv
// Host-side response stream: one Dbw-bit word per valid/ready handshake, last-word flag.
interface puf_reader_if #(
    parameter int unsigned Dbw = 64
);
    logic [Dbw-1:0] m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/puf_reader.sv
// Launches a PUF run, checks the written-word count, then streams the response memory to the host.
// Define PUF_RD_XSUM_EN to append an XOR checksum beat after the last data word.
module puf_reader
    import puf_reader_pkg::*;
#(
    parameter int unsigned Bpc    = BPC,
    parameter int unsigned Dbw    = DBW,
    parameter int unsigned Mnc    = MNC,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic [1:0]                          cfg_cnfa,
    input  logic                                cfg_bg,
    input  logic                                cfg_sd,
    input  logic [$clog2(Mnc):0]                cfg_ncmps,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic                                puf_str,
    output logic                                BG,
    output logic                                SD,
    output logic [1:0]                          cnfa,
    output logic [$clog2(Mnc):0]                n_cmps,
    output logic [$clog2(Mnc*Bpc/Dbw-1)-1:0]    puf_addr,
    input  logic [$clog2(Mnc*Bpc/Dbw):0]        puf_addw,
    input  logic                                puf_end,
    input  logic [Dbw-1:0]                      puf_out,
    puf_reader_if.master                        host
);

    localparam int unsigned CW  = $clog2(Mnc) + 1;
    localparam int unsigned AW  = $clog2(Mnc * Bpc / Dbw - 1);
    localparam int unsigned NWW = $clog2(Mnc * Bpc / Dbw) + 1;
    localparam int unsigned CPW = Dbw / Bpc;

    puf_state_e     state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [1:0]     lat_q, lat_d;
    logic [Dbw-1:0] data_q, data_d;
    logic [NWW-1:0] nw_q, nw_d;
    logic           err_q, err_d;
    logic           puf_end_q;
    logic [1:0]     cnfa_q, cnfa_d;
    logic           bg_q, bg_d;
    logic           sd_q, sd_d;
    logic [CW-1:0]  ncmps_q, ncmps_d;

    logic           cfg_ok;
    logic [NWW-1:0] nw_calc;
    logic           last_word;
    logic           end_rise;

    assign cfg_ok = (cfg_ncmps != '0) && (cfg_ncmps <= CW'(Mnc)) &&
                    ((cfg_ncmps % CW'(CPW)) == '0);
    assign nw_calc   = NWW'(cfg_ncmps / CW'(CPW));
    assign last_word = (NWW'(addr_q) == nw_q - NWW'(1));
    // A level already high when RUN is entered must not count as completion.
    assign end_rise  = puf_end && !puf_end_q;

`ifdef PUF_RD_XSUM_EN
    logic [Dbw-1:0] acc_q, acc_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        data_d  = data_q;
        nw_d    = nw_q;
        err_d   = err_q;
        cnfa_d  = cnfa_q;
        bg_d    = bg_q;
        sd_d    = sd_q;
        ncmps_d = ncmps_q;
`ifdef PUF_RD_XSUM_EN
        acc_d   = acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cnfa_d  = cfg_cnfa;
                    bg_d    = cfg_bg;
                    sd_d    = cfg_sd;
                    ncmps_d = cfg_ncmps;
                    nw_d    = nw_calc;
`ifdef PUF_RD_XSUM_EN
                    acc_d   = '0;
`endif
                    if (cfg_ok) begin
                        err_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (end_rise) begin
                    if (puf_addw != nw_q) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d  = '0;
                        lat_d   = '0;
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                // One extra cycle beyond RD_LAT lets a registered RAM output settle.
                if (lat_q == 2'(RD_LAT)) begin
                    data_d  = puf_out;
`ifdef PUF_RD_XSUM_EN
                    acc_d   = acc_q ^ puf_out;
`endif
                    state_d = StHold;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StHold: begin
                if (host.m_ready) begin
                    if (last_word) begin
`ifdef PUF_RD_XSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        lat_d   = '0;
                        state_d = StAddr;
                    end
                end
            end
`ifdef PUF_RD_XSUM_EN
            StCsum: begin
                if (host.m_ready) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            lat_q     <= '0;
            data_q    <= '0;
            nw_q      <= '0;
            err_q     <= 1'b0;
            puf_end_q <= 1'b0;
            cnfa_q    <= '0;
            bg_q      <= 1'b0;
            sd_q      <= 1'b0;
            ncmps_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lat_q     <= lat_d;
            data_q    <= data_d;
            nw_q      <= nw_d;
            err_q     <= err_d;
            puf_end_q <= puf_end;
            cnfa_q    <= cnfa_d;
            bg_q      <= bg_d;
            sd_q      <= sd_d;
            ncmps_q   <= ncmps_d;
        end
    end

`ifdef PUF_RD_XSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign host.m_valid = (state_q == StHold) || (state_q == StCsum);
    assign host.m_data  = (state_q == StCsum) ? acc_q : data_q;
    assign host.m_last  = (state_q == StCsum);
`else
    assign host.m_valid = (state_q == StHold);
    assign host.m_data  = data_q;
    assign host.m_last  = (state_q == StHold) && last_word;
`endif

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign puf_str  = (state_q == StRun);
    assign error    = err_q;
    assign cnfa     = cnfa_q;
    assign BG       = bg_q;
    assign SD       = sd_q;
    assign n_cmps   = ncmps_q;
    assign puf_addr = addr_q;

endmodule

// File: tb/tb_puf_reader.sv
// Directed bench for puf_reader: PUF memory model, beat scoreboard, immediate-assertion checks.
module tb_puf_reader;
    import puf_reader_pkg::*;

    localparam int END_AT = 50;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          cfg_cnfa = '0;
    logic                cfg_bg = 1'b0;
    logic                cfg_sd = 1'b0;
    logic [NCMPS_W-1:0]  cfg_ncmps = '0;
    logic                busy, done, error, puf_str, BG, SD;
    logic [1:0]          cnfa;
    logic [NCMPS_W-1:0]  n_cmps;
    logic [ADDR_W-1:0]   puf_addr;
    logic [ADDW_W-1:0]   puf_addw = '0;
    logic                puf_end = 1'b0;
    logic [DBW-1:0]      puf_out = '0;
    logic                ready = 1'b1;

    puf_reader_if #(.Dbw(DBW)) host_if ();
    assign host_if.m_ready = ready;

    puf_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cfg_cnfa  (cfg_cnfa),
        .cfg_bg    (cfg_bg),
        .cfg_sd    (cfg_sd),
        .cfg_ncmps (cfg_ncmps),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .puf_str   (puf_str),
        .BG        (BG),
        .SD        (SD),
        .cnfa      (cnfa),
        .n_cmps    (n_cmps),
        .puf_addr  (puf_addr),
        .puf_addw  (puf_addw),
        .puf_end   (puf_end),
        .puf_out   (puf_out),
        .host      (host_if.master)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // PUF model: registered read port, puf_end dropped early in the run and raised END_AT later.
    logic [DBW-1:0]    mem [256];
    int                puf_cnt = 0;
    bit                lower_en = 1'b1;
    logic [ADDW_W-1:0] addw_cfg = '0;

    always @(posedge clock) begin
        puf_out <= mem[puf_addr];
        if (puf_str) begin
            puf_cnt <= puf_cnt + 1;
            if (puf_cnt == 2 && lower_en) puf_end <= 1'b0;
            if (puf_cnt == END_AT) begin
                puf_end  <= 1'b1;
                puf_addw <= addw_cfg;
            end
        end else begin
            puf_cnt <= 0;
        end
    end

    typedef struct {
        logic [63:0] data;
        logic        last;
        bit          gap;
    } beat_t;

    beat_t       exp_q[$];
    int          beats = 0;
    int          cyc = 0;
    int          last_hs = -1;
    bit          stalled = 1'b0;
    logic [63:0] stall_data = '0;
    bit          ready_tog = 1'b0;
    bit          rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        beat_t e;
        if (reset) begin
            stalled = 1'b0;
        end else if (host_if.m_valid) begin
            if (stalled) check("stall_stable", host_if.m_data, stall_data);
            if (ready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", host_if.m_data, e.data);
                    check("beat_last", 64'(host_if.m_last), 64'(e.last));
                    if (e.gap && !ready_tog) check("beat_spacing", 64'(cyc - last_hs), 64'd3);
                end
                beats++;
                last_hs = cyc;
                stalled = 1'b0;
            end else begin
                stalled    = 1'b1;
                stall_data = host_if.m_data;
            end
        end
    end

    task automatic fill_mem(input logic [63:0] base);
        for (int i = 0; i < 256; i++) mem[i] = base + 64'(i);
    endtask

    task automatic push_beats(input int nw);
        logic [63:0] acc = '0;
        for (int i = 0; i < nw; i++) begin
            beat_t b;
            b.data = mem[i];
            b.gap  = (i > 0);
`ifdef PUF_RD_XSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == nw - 1);
`endif
            acc = acc ^ mem[i];
            exp_q.push_back(b);
        end
`ifdef PUF_RD_XSUM_EN
        begin
            beat_t c;
            c.data = acc;
            c.last = 1'b1;
            c.gap  = 1'b0;
            exp_q.push_back(c);
        end
`endif
    endtask

    task automatic do_start(input logic [NCMPS_W-1:0] n);
        logic [1:0] e_cnfa;
        logic       e_bg, e_sd;
        @(posedge clock); #1;
        e_cnfa    = 2'($urandom);
        e_bg      = 1'($urandom);
        e_sd      = 1'($urandom);
        cfg_ncmps = n;
        cfg_cnfa  = e_cnfa;
        cfg_bg    = e_bg;
        cfg_sd    = e_sd;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        cfg_cnfa  = ~e_cnfa;
        cfg_bg    = ~e_bg;
        cfg_sd    = ~e_sd;
        cfg_ncmps = ~n;
        check("start_busy", 64'(busy), 64'd1);
        check("latch_cnfa", 64'(cnfa), 64'(e_cnfa));
        check("latch_bg_sd", 64'({BG, SD}), 64'({e_bg, e_sd}));
        check("latch_ncmps", 64'(n_cmps), 64'(n));
    endtask

    task automatic run_case(input string tag, input int n, input int addw, input bit tog,
                            input int budget);
        bit ok, match;
        int nw, nb, b0, done_cnt, done_at, str_cyc;
        ok    = (n != 0) && (n <= 4096) && (n % 16 == 0);
        nw    = n / 16;
        match = ok && (addw == nw);
        nb    = 0;
        fill_mem({32'($urandom), 32'hA5A5_A500});
        if (match) begin
            push_beats(nw);
            nb = nw;
`ifdef PUF_RD_XSUM_EN
            nb = nw + 1;
`endif
        end
        addw_cfg  = ADDW_W'(addw);
        ready_tog = tog;
        b0        = beats;
        do_start(NCMPS_W'(n));
        done_cnt = 0;
        done_at  = -1;
        str_cyc  = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock); #1;
            if (puf_str) str_cyc++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c >= done_at + 2) break;
            @(posedge clock); #1;
            ready = tog ? rpat[c % 4] : 1'b1;
        end
        ready = 1'b1;
        $display("case %s: beats=%0d done_at=%0d", tag, beats - b0, done_at);
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_error"}, 64'(error), 64'(!match));
        check({tag, "_beats"}, 64'(beats - b0), 64'(nb));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        if (ok) check({tag, "_str_cycles"}, 64'(str_cyc), 64'(END_AT + 2));
        else begin
            check({tag, "_str_never"}, 64'(str_cyc), 64'd0);
            check({tag, "_done_fast"}, 64'(done_at >= 0 && done_at < 2), 64'd1);
        end
        if (match) check({tag, "_addr_hold"}, 64'(puf_addr), 64'(nw - 1));
        exp_q.delete();
    endtask

    initial begin
        int b0;
        fill_mem(64'hA5A5_A5A5_A5A5_A500);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_str", 64'(puf_str), 64'd0);
        check("rst_valid", 64'(host_if.m_valid), 64'd0);
        check("rst_last", 64'(host_if.m_last), 64'd0);
        check("rst_data", host_if.m_data, 64'd0);
        check("rst_pufout", 64'({puf_addr, cnfa, BG, SD, n_cmps}), 64'd0);

        run_case("basic", 128, 8, 1'b0, 300);
        run_case("stall", 128, 8, 1'b1, 400);
        run_case("zero", 0, 8, 1'b0, 20);
        run_case("over", 4097, 8, 1'b0, 20);
        run_case("nonmult", 100, 8, 1'b0, 20);
        run_case("mismatch", 128, 7, 1'b0, 200);
        run_case("single", 16, 1, 1'b0, 200);
        run_case("full", 4096, 256, 1'b0, 1300);

        // Reset while the third beat is stalled in HOLD.
        fill_mem(64'h0123_4567_89AB_C000);
        push_beats(8);
        addw_cfg = ADDW_W'(8);
        b0 = beats;
        do_start(NCMPS_W'(128));
        for (int c = 0; c < 200; c++) begin
            @(negedge clock); #1;
            if (beats - b0 >= 2) break;
        end
        @(posedge clock); #1 ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock); #1;
            if (host_if.m_valid) break;
        end
        check("hold3_valid", 64'(host_if.m_valid), 64'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        check("rstrun_valid", 64'(host_if.m_valid), 64'd0);
        check("rstrun_str", 64'(puf_str), 64'd0);
        check("rstrun_busy", 64'(busy), 64'd0);
        check("rstrun_done", 64'(done), 64'd0);
        check("rstrun_beats", 64'(beats - b0), 64'd2);
        ready = 1'b1;
        exp_q.delete();
        run_case("after_rst", 128, 8, 1'b0, 300);

        // puf_end stays high from the previous run: no rising edge, so the reader must wait.
        lower_en = 1'b0;
        b0 = beats;
        do_start(NCMPS_W'(128));
        repeat (END_AT + 20) @(negedge clock);
        #1;
        check("stale_busy", 64'(busy), 64'd1);
        check("stale_str", 64'(puf_str), 64'd1);
        check("stale_beats", 64'(beats - b0), 64'd0);
        @(posedge clock); #1;
        cfg_ncmps = NCMPS_W'(16);
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check("busy_start_ignored", 64'(n_cmps), 64'd128);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        check("stale_rst_busy", 64'(busy), 64'd0);
        lower_en = 1'b1;
        run_case("new_edge", 128, 8, 1'b0, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
